// File: rtl/memory_stage_ctrl_if.sv
// Data-memory request/response bus between the memory-stage controller (master)
// and the data memory (slave).
interface memory_stage_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/memory_stage_ctrl.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers plus the load/store handshake FSM.
// Optional MEM_TIMEOUT_EN adds a watchdog that aborts an access after TIMEOUT_CYC wait cycles.
module memory_stage_ctrl #(
    parameter int DATA_W      = 16,
    parameter int RD_W        = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exValid_i,
    input  logic [DATA_W-1:0] exOut_i,
    input  logic [DATA_W-1:0] exMemAddr_i,
    input  logic [DATA_W-1:0] exStoreData_i,
    input  logic              exMemRd_i,
    input  logic              exMemWr_i,
    input  logic              exWbEn_i,
    input  logic [RD_W-1:0]   exRd_i,
    output logic              stall_o,
    memory_stage_ctrl_if.master dmem,
    output logic [DATA_W-1:0] exmemFwd_o,
    output logic [RD_W-1:0]   exmemRd_o,
    output logic              exmemWbEn_o,
    output logic              exmemIsLoad_o,
    output logic [DATA_W-1:0] memwbFwd_o,
    output logic              wbValid_o,
    output logic              wbEn_o,
    output logic [RD_W-1:0]   wbRd_o,
    output logic [DATA_W-1:0] wbData_o,
    output logic              memFault_o
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q;
    logic              emValid_q, emLoad_q, emStore_q, emWbEn_q;
    logic [DATA_W-1:0] emOut_q, emAddr_q, emData_q;
    logic [RD_W-1:0]   emRd_q;
    logic              gap_q;
    logic              wbValid_q, wbEn_q;
    logic [RD_W-1:0]   wbRd_q;
    logic [DATA_W-1:0] wbData_q;

    logic              wbValid_d, wbEn_d;
    logic [RD_W-1:0]   wbRd_d;
    logic [DATA_W-1:0] wbData_d;

    logic isStore, isLoad, memOp, nonMem, req, ackDone, timeoutHit, done;

    assign isStore = emStore_q;
    assign isLoad  = emLoad_q & ~emStore_q;
    assign memOp   = emValid_q & (isLoad | isStore);
    assign nonMem  = emValid_q & ~(isLoad | isStore);
    // gap_q forces one idle cycle after any completed access before the next request
    assign req     = memOp & ~gap_q;
    assign ackDone = req & dmem.ack;
    assign done    = ackDone | timeoutHit;
    assign stall_o = memOp & ~done;

    assign dmem.req   = req;
    assign dmem.we    = req & isStore;
    assign dmem.addr  = emAddr_q;
    assign dmem.wdata = emData_q;

    assign exmemFwd_o    = emOut_q;
    assign exmemRd_o     = emRd_q;
    assign exmemWbEn_o   = emValid_q & emWbEn_q;
    assign exmemIsLoad_o = emValid_q & isLoad;
    assign memwbFwd_o    = wbData_q;
    assign wbValid_o     = wbValid_q;
    assign wbEn_o        = wbValid_q & wbEn_q;
    assign wbRd_o        = wbRd_q;
    assign wbData_o      = wbData_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             fault_q;

    assign timeoutHit = req & ~dmem.ack & (state_q == WAIT) & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign memFault_o = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state_q == WAIT && req && !done) cnt_q <= cnt_q + CNT_W'(1);
            else                                  cnt_q <= '0;
            if (timeoutHit) fault_q <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign memFault_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
        end else begin
            gap_q <= done;
            case (state_q)
                IDLE:    if (req && !done) state_q <= WAIT;
                WAIT:    if (done || !req) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A timed-out load retires as a non-writing zero; a timed-out store simply vanishes
    always_comb begin
        wbValid_d = 1'b0;
        wbEn_d    = wbEn_q;
        wbRd_d    = wbRd_q;
        wbData_d  = wbData_q;
        if (nonMem) begin
            wbValid_d = 1'b1;
            wbEn_d    = emWbEn_q;
            wbRd_d    = emRd_q;
            wbData_d  = emOut_q;
        end else if (ackDone) begin
            wbValid_d = 1'b1;
            wbEn_d    = emWbEn_q & isLoad;
            wbRd_d    = emRd_q;
            wbData_d  = isLoad ? dmem.rdata : emOut_q;
        end else if (timeoutHit && isLoad) begin
            wbValid_d = 1'b1;
            wbEn_d    = 1'b0;
            wbRd_d    = emRd_q;
            wbData_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emValid_q <= 1'b0;
            emLoad_q  <= 1'b0;
            emStore_q <= 1'b0;
            emWbEn_q  <= 1'b0;
            emOut_q   <= '0;
            emAddr_q  <= '0;
            emData_q  <= '0;
            emRd_q    <= '0;
            wbValid_q <= 1'b0;
            wbEn_q    <= 1'b0;
            wbRd_q    <= '0;
            wbData_q  <= '0;
        end else begin
            if (!stall_o) begin
                emValid_q <= exValid_i;
                emLoad_q  <= exMemRd_i;
                emStore_q <= exMemWr_i;
                emWbEn_q  <= exWbEn_i;
                emOut_q   <= exOut_i;
                emAddr_q  <= exMemAddr_i;
                emData_q  <= exStoreData_i;
                emRd_q    <= exRd_i;
            end
            wbValid_q <= wbValid_d;
            wbEn_q    <= wbEn_d;
            wbRd_q    <= wbRd_d;
            wbData_q  <= wbData_d;
        end
    end
endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Scoreboard bench for memory_stage_ctrl: a transaction-level model predicts every retired
// instruction; a behavioural memory with random latency and spurious acks drives the bus.
`timescale 1ns/1ps
module tb_memory_stage_ctrl;
    localparam int DATA_W      = 16;
    localparam int RD_W        = 3;
    localparam int TIMEOUT_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              exValid = 1'b0, exMemRd = 1'b0, exMemWr = 1'b0, exWbEn = 1'b0;
    logic [DATA_W-1:0] exOut = '0, exMemAddr = '0, exStoreData = '0;
    logic [RD_W-1:0]   exRd = '0;
    logic              stall, exmemWbEn, exmemIsLoad, wbValid, wbEn, memFault;
    logic [DATA_W-1:0] exmemFwd, memwbFwd, wbData;
    logic [RD_W-1:0]   exmemRd, wbRd;

    memory_stage_ctrl_if #(.DATA_W(DATA_W)) dmemBus();

    memory_stage_ctrl #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .exValid_i(exValid), .exOut_i(exOut), .exMemAddr_i(exMemAddr),
        .exStoreData_i(exStoreData), .exMemRd_i(exMemRd), .exMemWr_i(exMemWr),
        .exWbEn_i(exWbEn), .exRd_i(exRd), .stall_o(stall), .dmem(dmemBus),
        .exmemFwd_o(exmemFwd), .exmemRd_o(exmemRd), .exmemWbEn_o(exmemWbEn),
        .exmemIsLoad_o(exmemIsLoad), .memwbFwd_o(memwbFwd), .wbValid_o(wbValid),
        .wbEn_o(wbEn), .wbRd_o(wbRd), .wbData_o(wbData), .memFault_o(memFault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              en;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wbExp_t;

    wbExp_t            expQ[$];
    wbExp_t            monExp;
    logic [DATA_W-1:0] refMem [logic [DATA_W-1:0]];
    logic [DATA_W-1:0] memArr [logic [DATA_W-1:0]];
    int                total = 0, bad = 0;
    int                fixedLat = -1, spurProb = 0;
    bit                neverAck = 1'b0, timeoutMode = 1'b0;
    int                stallCycles = 0, reqCycles = 0;
    bit                prevReq = 1'b0, prevAck = 1'b0, prevWe = 1'b0;
    logic [DATA_W-1:0] prevAddr = '0, prevWdata = '0, lastReqAddr = '0;
    bit                lastReqWe = 1'b0;
    int                waitCnt = 0, target = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Behavioural data memory: programmable latency, writes commit on the ack it raises
    initial begin
        dmemBus.ack   = 1'b0;
        dmemBus.rdata = '0;
    end
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            dmemBus.ack = 1'b0;
            waitCnt     = 0;
        end else if (dmemBus.req) begin
            if (waitCnt == 0) target = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
            if (!neverAck && waitCnt >= target) begin
                dmemBus.ack = 1'b1;
                waitCnt     = 0;
                if (dmemBus.we) memArr[dmemBus.addr] = dmemBus.wdata;
                else dmemBus.rdata = memArr.exists(dmemBus.addr) ? memArr[dmemBus.addr] : '0;
            end else begin
                dmemBus.ack   = 1'b0;
                dmemBus.rdata = DATA_W'($urandom);
                waitCnt++;
            end
        end else begin
            dmemBus.ack   = ($urandom_range(0, 99) < spurProb);
            dmemBus.rdata = DATA_W'($urandom);
            waitCnt       = 0;
        end
    end

    // Monitor: bus-stability checks, retire comparison, and prediction on each accepted issue
    always @(negedge clk) begin
        if (!rst_n) begin
            prevReq = 1'b0;
            prevAck = 1'b0;
        end else begin
            if (stall) stallCycles++;
            if (dmemBus.req) begin
                reqCycles++;
                lastReqAddr = dmemBus.addr;
                lastReqWe   = dmemBus.we;
            end
            if (prevReq && !prevAck && !timeoutMode) begin
                checkOutput("req_held", dmemBus.req, 1'b1);
                checkOutput("addr_held", dmemBus.addr, prevAddr);
                checkOutput("wdata_held", dmemBus.wdata, prevWdata);
                checkOutput("we_held", dmemBus.we, prevWe);
            end
            prevReq   = dmemBus.req;
            prevAck   = dmemBus.ack;
            prevWe    = dmemBus.we;
            prevAddr  = dmemBus.addr;
            prevWdata = dmemBus.wdata;

            if (wbValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL wb_unexpected actual=1 expected=0 (rd=%0d data=%0h)", wbRd, wbData);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("wb_en", wbEn, monExp.en);
                    checkOutput("wb_rd", wbRd, monExp.rd);
                    checkOutput("wb_data", wbData, monExp.data);
                    checkOutput("memwb_fwd", memwbFwd, monExp.data);
                end
            end else begin
                checkOutput("wb_en_idle", wbEn, 1'b0);
            end

            if (exValid && !stall) begin
                if (exMemRd) begin
                    if (timeoutMode) expQ.push_back('{en: 1'b0, rd: exRd, data: '0});
                    else expQ.push_back('{en: exWbEn, rd: exRd,
                                          data: refMem.exists(exMemAddr) ? refMem[exMemAddr] : '0});
                end else if (exMemWr) begin
                    if (!timeoutMode) begin
                        refMem[exMemAddr] = exStoreData;
                        expQ.push_back('{en: 1'b0, rd: exRd, data: exOut});
                    end
                end else begin
                    expQ.push_back('{en: exWbEn, rd: exRd, data: exOut});
                end
            end
        end
    end

    // Called and returns at posedge+1; holds the instruction until it is accepted
    task automatic applyStimulus(input logic ld, input logic st, input logic wben,
                                 input logic [DATA_W-1:0] out, input logic [DATA_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic [RD_W-1:0] rd);
        int guard = 0;
        exValid = 1'b1; exMemRd = ld; exMemWr = st; exWbEn = wben;
        exOut = out; exMemAddr = addr; exStoreData = data; exRd = rd;
        do begin
            @(negedge clk);
            guard++;
        end while (stall && guard < 100);
        if (stall) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=stalled expected=accepted");
        end
        @(posedge clk);
        #1;
        exValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int s0, r0;
        logic k;
        #2 rst_n = 1'b0;
        #20;
        checkOutput("rst_req", dmemBus.req, 1'b0);
        checkOutput("rst_stall", stall, 1'b0);
        checkOutput("rst_wb_valid", wbValid, 1'b0);
        checkOutput("rst_wb_en", wbEn, 1'b0);
        checkOutput("rst_wb_data", wbData, 16'h0);
        checkOutput("rst_exmem_fwd", exmemFwd, 16'h0);
        checkOutput("rst_exmem_is_load", exmemIsLoad, 1'b0);
        checkOutput("rst_mem_fault", memFault, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] ALU op");
        s0 = stallCycles;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0, 16'h0, 3'd3);
        checkOutput("alu_exmem_fwd", exmemFwd, 16'h1234);
        checkOutput("alu_exmem_rd", exmemRd, 3'd3);
        checkOutput("alu_exmem_wb_en", exmemWbEn, 1'b1);
        idleCycles(1);
        checkOutput("alu_wb_valid", wbValid, 1'b1);
        checkOutput("alu_wb_data", wbData, 16'h1234);
        checkOutput("alu_wb_rd", wbRd, 3'd3);
        idleCycles(2);
        checkOutput("alu_no_stall", stallCycles - s0, 0);

        $display("[TB] load with 3-cycle ack latency");
        memArr[16'h0010] = 16'hBEEF;
        refMem[16'h0010] = 16'hBEEF;
        fixedLat = 2;
        s0 = stallCycles; r0 = reqCycles;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0, 3'd2);
        idleCycles(6);
        checkOutput("load_stall_cycles", stallCycles - s0, 2);
        checkOutput("load_req_cycles", reqCycles - r0, 3);
        checkOutput("load_addr", lastReqAddr, 16'h0010);

        $display("[TB] zero-wait store");
        fixedLat = 0;
        s0 = stallCycles; r0 = reqCycles;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0040, 16'h00AA, 3'd0);
        idleCycles(4);
        checkOutput("store_stall_cycles", stallCycles - s0, 0);
        checkOutput("store_req_cycles", reqCycles - r0, 1);
        checkOutput("store_we", lastReqWe, 1'b1);
        checkOutput("store_mem", memArr.exists(16'h0040) ? memArr[16'h0040] : 16'h0, 16'h00AA);

        $display("[TB] load then dependent ALU op, spurious ack");
        fixedLat = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0, 3'd4);
        checkOutput("dep_exmem_is_load", exmemIsLoad, 1'b1);
        checkOutput("dep_exmem_rd", exmemRd, 3'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h7777, 16'h0, 16'h0, 3'd5);
        idleCycles(4);
        spurProb = 100;
        idleCycles(4);
        checkOutput("spur_wb_valid", wbValid, 1'b0);
        checkOutput("spur_stall", stall, 1'b0);
        checkOutput("spur_exmem_is_load", exmemIsLoad, 1'b0);
        spurProb = 0;

        $display("[TB] reset during WAIT");
        neverAck = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0010, 16'h0, 3'd7);
        idleCycles(2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", dmemBus.req, 1'b0);
        checkOutput("midrst_stall", stall, 1'b0);
        checkOutput("midrst_wb_valid", wbValid, 1'b0);
        expQ.delete();
        neverAck = 1'b0;
        spurProb = 100;
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(4);
        checkOutput("postrst_wb_valid", wbValid, 1'b0);
        checkOutput("postrst_req", dmemBus.req, 1'b0);
        spurProb = 0;

        $display("[TB] randomized traffic");
        fixedLat = -1;
        spurProb = 25;
        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            k    = 1'($urandom);
            applyStimulus(kind == 1, kind == 2, (kind == 2) ? 1'b0 : k, DATA_W'($urandom),
                          16'h0100 + DATA_W'($urandom_range(0, 7)), DATA_W'($urandom),
                          RD_W'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
        spurProb = 0;
        idleCycles(10);
        checkOutput("queue_drained", expQ.size(), 0);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        neverAck = 1'b1;
        timeoutMode = 1'b1;
        r0 = reqCycles;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0, 3'd6);
        idleCycles(8);
        checkOutput("timeout_req_cycles", reqCycles - r0, 1 + TIMEOUT_CYC);
        checkOutput("timeout_fault", memFault, 1'b1);
        timeoutMode = 1'b0;
        neverAck = 1'b0;
        fixedLat = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555, 16'h0, 16'h0, 3'd1);
        idleCycles(3);
        checkOutput("timeout_resume", expQ.size(), 0);
        checkOutput("timeout_fault_sticky", memFault, 1'b1);
`else
        checkOutput("no_fault", memFault, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
